// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues word fetches, queues returned instrs.
// Define IFETCH_STALL_CNT_EN to add the saturating stall_cnt output.
module instr_fetch_queue #(
    parameter int             N        = 32,
    parameter int             DEPTH    = 2,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_valid,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         instr_valid,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    input  logic         instr_ready
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] CAP  = CW'(DEPTH);
    localparam logic [N-1:0]  STEP = N'(4);

    logic [N-1:0]  pc;
    logic [N-1:0]  q_instr [DEPTH];
    logic [N-1:0]  q_pc    [DEPTH];
    logic [N-1:0]  req_pc  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] req_wr;
    logic [AW-1:0] req_rd;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] used;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits    = ^redirect_pc[1:0];
    assign used           = count + outstanding;
    assign imem_req_valid = rst_n & ~redirect_valid & (used < CAP);
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid & imem_req_ready;
    assign push           = imem_rsp_valid & ~redirect_valid
                          & (drop_cnt == '0);
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid & instr_ready & ~redirect_valid;
    assign instr          = q_instr[head];
    assign instr_pc       = q_pc[head];

    // PC steps on each accepted fetch; a redirect reloads it word-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= {RESET_PC[N-1:2], 2'b00};
        end else if (redirect_valid) begin
            pc <= {redirect_pc[N-1:2], 2'b00};
        end else if (issue) begin
            pc <= pc + STEP;
        end
    end

    // Request PC FIFO: written at issue, advanced by every response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr <= '0;
            req_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                req_pc[i] <= '0;
            end
        end else begin
            if (issue) begin
                req_pc[req_wr] <= pc;
                req_wr         <= req_wr + 1'b1;
            end
            if (imem_rsp_valid) begin
                req_rd <= req_rd + 1'b1;
            end
        end
    end

    // In-flight count and number of stale responses still to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue)
                         - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else if (imem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // In-order instruction queue; a redirect flushes it and blocks pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_instr[tail] <= imem_rsp_data;
                q_pc[tail]    <= req_pc[req_rd];
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Issue gating means a kept response never meets a full queue.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == CAP));

`ifdef IFETCH_STALL_CNT_EN
    // Count cycles where decode waits on an empty queue; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (instr_ready && !instr_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order latency memory.
// Stall counter checks run when IFETCH_STALL_CNT_EN is defined.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .N(32),
        .DEPTH(2),
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req_v;
        logic [31:0] req_a;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_addr[$];
    int          m_due[$];
    logic [31:0] iss_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_issued = 0;
    logic        req_fire = 1'b0;
    logic        rsp_fire = 1'b0;
    logic [31:0] fire_addr = '0;

    function automatic logic [31:0] mdata(logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mkv(bit rst, bit rdy, bit rv,
                                 logic [31:0] ra, bit iv,
                                 logic [31:0] ip);
        vec_t v;
        v.rst = rst;
        v.rdy = rdy;
        v.req_v = rv;
        v.req_a = ra;
        v.iv = iv;
        v.ipc = ip;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive_rsp();
        if (m_addr.size() > 0 && m_due[0] <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(m_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        req_fire  = imem_req_valid & imem_req_ready;
        rsp_fire  = imem_rsp_valid;
        fire_addr = imem_req_addr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_fire && m_addr.size() > 0) begin
            void'(m_addr.pop_front());
            void'(m_due.pop_front());
        end
        if (req_fire) begin
            m_addr.push_back(fire_addr);
            m_due.push_back(cyc + lat);
            iss_log.push_back(fire_addr);
            n_issued++;
        end
        drive_rsp();
    endtask

    task automatic do_reset(int l);
        rst_n = 1'b0;
        lat = l;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        m_addr.delete();
        m_due.delete();
        iss_log.delete();
        n_issued = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_iv(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (instr_valid) begin
                ok = 1'b1;
                return;
            end
            advance();
        end
    endtask

    vec_t        vt[$];
    logic [31:0] got[$];
    logic [31:0] wexp[4];
    bit          ok;

    initial begin
        // stream with ready decode, then a decode stall filling the queue
        vt.push_back(mkv(1, 1, 1, 32'h100, 0, 0));
        vt.push_back(mkv(0, 1, 1, 32'h104, 0, 0));
        vt.push_back(mkv(0, 1, 0, 0, 1, 32'h100));
        vt.push_back(mkv(0, 1, 1, 32'h108, 1, 32'h104));
        vt.push_back(mkv(0, 1, 1, 32'h10C, 0, 0));
        vt.push_back(mkv(0, 1, 0, 0, 1, 32'h108));
        vt.push_back(mkv(0, 1, 1, 32'h110, 1, 32'h10C));
        vt.push_back(mkv(1, 0, 1, 32'h100, 0, 0));
        vt.push_back(mkv(0, 0, 1, 32'h104, 0, 0));
        for (int k = 0; k < 8; k++)
            vt.push_back(mkv(0, 0, 0, 0, 1, 32'h100));
        vt.push_back(mkv(0, 1, 0, 0, 1, 32'h100));
        vt.push_back(mkv(0, 1, 1, 32'h108, 1, 32'h104));
        vt.push_back(mkv(0, 1, 1, 32'h10C, 0, 0));
        vt.push_back(mkv(0, 1, 0, 0, 1, 32'h108));

        // reset values while rst_n is low
        @(negedge clk);
        @(negedge clk);
        chk("rst req_valid", imem_req_valid, 0);
        chk("rst instr_valid", instr_valid, 0);
        chk("rst instr", instr, 0);
        chk("rst instr_pc", instr_pc, 0);
`ifdef IFETCH_STALL_CNT_EN
        chk("rst stall_cnt", stall_cnt, 0);
`endif

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset(1);
            instr_ready = vt[i].rdy;
            sample();
            chk($sformatf("v%0d req_valid", i),
                imem_req_valid, vt[i].req_v);
            if (vt[i].req_v)
                chk($sformatf("v%0d req_addr", i),
                    imem_req_addr, vt[i].req_a);
            chk($sformatf("v%0d instr_valid", i),
                instr_valid, vt[i].iv);
            if (vt[i].iv) begin
                chk($sformatf("v%0d instr_pc", i),
                    instr_pc, vt[i].ipc);
                chk($sformatf("v%0d instr", i),
                    instr, mdata(vt[i].ipc));
            end
            advance();
        end
        chk("stall issued", n_issued, 4);

        // latency 3, redirect with two fetches in flight
        do_reset(3);
        sample();
        chk("s3 t0 addr", imem_req_addr, 32'h100);
        advance();
        sample();
        advance();
        redirect_valid = 1'b1;
        redirect_pc = 32'h2003;
        sample();
        chk("s3 redir req_valid", imem_req_valid, 0);
        advance();
        redirect_valid = 1'b0;
        wait_iv(20, ok);
        chk("s3 got instr", ok, 1);
        chk("s3 instr_pc", instr_pc, 32'h2000);
        chk("s3 instr", instr, mdata(32'h2000));
        chk("s3 resume addr",
            (iss_log.size() > 2) ? iss_log[2] : 32'hX,
            32'h2000);
        advance();

        // redirect together with response and pop
        do_reset(1);
        sample();
        advance();
        sample();
        advance();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        sample();
        chk("s4 pre iv", instr_valid, 1);
        chk("s4 pre rsp", imem_rsp_valid, 1);
        advance();
        redirect_valid = 1'b0;
        sample();
        chk("s4 iv cleared", instr_valid, 0);
        chk("s4 drop_cnt", dut.drop_cnt, 0);
        chk("s4 req addr", imem_req_addr, 32'h300);
        advance();
        wait_iv(10, ok);
        chk("s4 got instr", ok, 1);
        chk("s4 instr_pc", instr_pc, 32'h300);
        advance();

        // address wrap at the top of the space
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        sample();
        chk("s5 redir req_valid", imem_req_valid, 0);
        advance();
        redirect_valid = 1'b0;
        got.delete();
        for (int k = 0; k < 30 && got.size() < 4; k++) begin
            sample();
            if (instr_valid) begin
                got.push_back(instr_pc);
                chk("s5 data", instr, mdata(instr_pc));
            end
            advance();
        end
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        wexp[3] = 32'h0000_0004;
        chk("s5 count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s5 pc%0d", k),
                (k < got.size()) ? got[k] : 32'hX, wexp[k]);
            chk($sformatf("s5 iss%0d", k),
                (k < iss_log.size()) ? iss_log[k] : 32'hX,
                wexp[k]);
        end

`ifdef IFETCH_STALL_CNT_EN
        // memory back-pressure with decode ready
        do_reset(1);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            advance();
        end
        imem_req_ready = 1'b1;
        sample();
        advance();
        sample();
        advance();
        sample();
        chk("s6 iv", instr_valid, 1);
        chk("s6 stall", stall_cnt, 7);
        advance();
        sample();
        chk("s6 iv2", instr_valid, 1);
        chk("s6 stall hold", stall_cnt, 7);
        advance();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
